clock_monitor: RTL and testbench

- Receive-side counterpart to the clock generator: takes a generated, possibly gated, clock as an asynchronous input and samples it in the system clock domain.
- Measures the monitored clock's period and high time in system cycles.
- Counts its rising edges.
- Flags a stopped (stuck) clock.
- Used by datapath benches and by on-chip status logic to confirm the generator is running and is being gated by its enable.

---
 rtl/clock_monitor_pkg.sv | 28 ++
 rtl/sync_edge_detect.sv | 33 +++
 rtl/clock_monitor.sv | 103 ++++++++++
 tb/tb_clock_monitor.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_monitor_pkg.sv
// Shared types and helpers for the monitored-clock checker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clock_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        RUN   = 2'd2,
        STUCK = 2'd3
    } mon_state_t;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_CNT_W       = 16;
    localparam int DEF_TIMEOUT     = 64;

    // Widest counter the helper below can saturate.
    localparam int SAT_MAX_W = 32;

    // Increment v, clamping at the all-ones value of a w-bit counter.
    function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] v,
                                                     input int w);
        logic [SAT_MAX_W-1:0] lim;
        lim = (SAT_MAX_W'(1) << w) - SAT_MAX_W'(1);
        return (v >= lim) ? lim : v + SAT_MAX_W'(1);
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronizes an async level into clk and flags its rising/falling edges.
// Latency: an input edge shows on rise/fall SYNC_STAGES clk edges later (combinational from flops).
// Backpressure: none; every sampled edge is reported for exactly one cycle.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2   // at least 2 for metastability settling
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_d;

    // Shift the async input through the synchronizer and keep the previous synced level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            level_d <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], async_in};
            level_d <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~level_d;
    assign fall  = ~level & level_d;

endmodule

// File: rtl/clock_monitor.sv
// Measures period/high time of an async monitored clock, counts its edges, flags a stopped clock.
// Latency: mon_clk edge to registered outputs is SYNC_STAGES+1 clk edges.
// Backpressure: none; period_valid is a single-cycle pulse with no ready.
module clock_monitor
    import clock_monitor_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             mon_clk,
    output logic             running,
    output logic             stuck,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic [CNT_W-1:0] edge_count
);

    // The synced level itself is not needed here; only its edges matter.
    logic mon_level_unused;
    logic mon_rise;
    logic mon_fall;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (mon_clk),
        .level    (mon_level_unused),
        .rise     (mon_rise),
        .fall     (mon_fall)
    );

    mon_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] ec_inc;
    logic             timeout_hit;

    // cnt_inc doubles as the measured interval: cnt counts cycles since the last edge minus one.
    assign cnt_inc     = CNT_W'(sat_inc(SAT_MAX_W'(cnt), CNT_W));
    assign ec_inc      = CNT_W'(sat_inc(SAT_MAX_W'(edge_count), CNT_W));
    assign timeout_hit = (cnt >= CNT_W'(TIMEOUT - 1));

    // Monitor FSM with interval counter and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            running      <= 1'b0;
            stuck        <= 1'b0;
            period       <= '0;
            high_time    <= '0;
            period_valid <= 1'b0;
            edge_count   <= '0;
        end else begin
            period_valid <= 1'b0;
            if (!enable) begin
                // Disable wins over any edge or timeout; measurements are kept for status reads.
                state   <= IDLE;
                cnt     <= '0;
                running <= 1'b0;
                stuck   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state      <= ARM;
                        cnt        <= '0;
                        edge_count <= '0;
                    end
                    default: begin
                        cnt <= mon_rise ? '0 : cnt_inc;
                        if (mon_rise) begin
                            edge_count <= ec_inc;
                            state      <= RUN;
                            running    <= 1'b1;
                            stuck      <= 1'b0;
                            // Only a rise that closes an interval started in RUN is a valid period;
                            // the first edge after arming or an outage has no clean start point.
                            if (state == RUN) begin
                                period       <= cnt_inc;
                                period_valid <= 1'b1;
                            end
                        end else if (state != STUCK && timeout_hit) begin
                            state   <= STUCK;
                            running <= 1'b0;
                            stuck   <= 1'b1;
                        end
                        if (state == RUN && mon_fall) begin
                            high_time <= cnt_inc;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clock_monitor.sv
// Directed bench for clock_monitor: default instance plus a narrow-counter instance.
// Expected period_valid results are queued at stimulus time and popped by monitors.
// Level outputs (running/stuck/edge_count) are checked inline at known cycle offsets.
module tb_clock_monitor;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic        mon_clk;
    logic        running;
    logic        stuck;
    logic [15:0] period;
    logic [15:0] high_time;
    logic        period_valid;
    logic [15:0] edge_count;

    logic        enable_s;
    logic        mon_s;
    logic        running_s;
    logic        stuck_s;
    logic [3:0]  period_s;
    logic [3:0]  high_time_s;
    logic        period_valid_s;
    logic [3:0]  edge_count_s;

    typedef struct {
        int per;
        int hi;
        int ec;
    } exp_t;

    exp_t q_m[$];
    exp_t q_s[$];

    int checks = 0;
    int fails  = 0;
    int edges_m = 0;
    int edges_s = 0;

    clock_monitor dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .mon_clk      (mon_clk),
        .running      (running),
        .stuck        (stuck),
        .period       (period),
        .high_time    (high_time),
        .period_valid (period_valid),
        .edge_count   (edge_count)
    );

    clock_monitor #(
        .SYNC_STAGES (2),
        .CNT_W       (4),
        .TIMEOUT     (15)
    ) dut_s (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable_s),
        .mon_clk      (mon_s),
        .running      (running_s),
        .stuck        (stuck_s),
        .period       (period_s),
        .high_time    (high_time_s),
        .period_valid (period_valid_s),
        .edge_count   (edge_count_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One monitored-clock cycle on the default instance, starting at a negedge.
    task automatic mon_cycle(input int per, input int hi);
        mon_clk = 1'b1;
        repeat (hi) @(negedge clk);
        mon_clk = 1'b0;
        repeat (per - hi) @(negedge clk);
    endtask

    // Same for the narrow instance.
    task automatic cyc_s(input int per, input int hi);
        mon_s = 1'b1;
        repeat (hi) @(negedge clk);
        mon_s = 1'b0;
        repeat (per - hi) @(negedge clk);
    endtask

    // Scoreboard monitor, default instance.
    always @(negedge clk) begin : mon_main
        exp_t e;
        if (period_valid) begin
            if (q_m.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_pv_main: got period_valid with period=%0d, expected none",
                         period);
            end else begin
                e = q_m.pop_front();
                check("pv_period_main", int'(period), e.per);
                check("pv_high_main", int'(high_time), e.hi);
                check("pv_edges_main", int'(edge_count), e.ec);
            end
        end
    end

    // Scoreboard monitor, narrow instance.
    always @(negedge clk) begin : mon_small
        exp_t e;
        if (period_valid_s) begin
            if (q_s.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_pv_small: got period_valid with period=%0d, expected none",
                         period_s);
            end else begin
                e = q_s.pop_front();
                check("pv_period_small", int'(period_s), e.per);
                check("pv_high_small", int'(high_time_s), e.hi);
                check("pv_edges_small", int'(edge_count_s), e.ec);
            end
        end
    end

    initial begin
        reset_n  = 1'b1;
        enable   = 1'b0;
        mon_clk  = 1'b0;
        enable_s = 1'b0;
        mon_s    = 1'b0;

        // Reset state
        #3 reset_n = 1'b0;
        #1;
        check("rst_running", int'(running), 0);
        check("rst_stuck", int'(stuck), 0);
        check("rst_period", int'(period), 0);
        check("rst_high", int'(high_time), 0);
        check("rst_pv", int'(period_valid), 0);
        check("rst_edges", int'(edge_count), 0);
        check("rst_edges_small", int'(edge_count_s), 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_running", int'(running), 0);

        // Latency: single rise during ARM
        enable = 1'b1;
        repeat (3) @(negedge clk);
        mon_clk = 1'b1;
        edges_m = 1;
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            if (j == 2) begin
                mon_clk = 1'b0;
                check("lat_running_e2", int'(running), 0);
                check("lat_edges_e2", int'(edge_count), 0);
            end
            if (j == 3) begin
                check("lat_running_e3", int'(running), 1);
                check("lat_edges_e3", int'(edge_count), 1);
            end
        end

        // Steady 4-cycle, 50% duty clock
        repeat (6) begin
            edges_m++;
            q_m.push_back('{4, 2, edges_m});
            mon_cycle(4, 2);
        end
        check("steady_running", int'(running), 1);
        check("steady_stuck", int'(stuck), 0);

        // Stuck: last rise then hold low
        edges_m++;
        q_m.push_back('{4, 2, edges_m});
        mon_clk = 1'b1;
        for (int j = 1; j <= 67; j++) begin
            @(negedge clk);
            if (j == 2) mon_clk = 1'b0;
            if (j == 66) begin
                check("stuck_early", int'(stuck), 0);
                check("running_early", int'(running), 1);
            end
            if (j == 67) begin
                check("stuck_set", int'(stuck), 1);
                check("running_clear", int'(running), 0);
            end
        end
        check("stuck_period_hold", int'(period), 4);
        repeat (5) @(negedge clk);

        // Restart from STUCK: no period on the first rise
        edges_m++;
        mon_clk = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            if (j == 2) begin
                mon_clk = 1'b0;
                check("restart_stuck_e2", int'(stuck), 1);
            end
            if (j == 3) begin
                check("restart_stuck_e3", int'(stuck), 0);
                check("restart_running", int'(running), 1);
                check("restart_edges", int'(edge_count), edges_m);
            end
        end
        edges_m++;
        q_m.push_back('{4, 2, edges_m});
        mon_cycle(4, 2);

        // Gating
        repeat (4) @(negedge clk);
        enable = 1'b0;
        repeat (5) @(negedge clk);
        check("gate_running", int'(running), 0);
        check("gate_stuck", int'(stuck), 0);
        check("gate_period", int'(period), 4);
        check("gate_high", int'(high_time), 2);
        check("gate_edges_hold", int'(edge_count), edges_m);
        enable = 1'b1;
        @(negedge clk);
        check("reen_edges", int'(edge_count), 0);
        check("reen_running", int'(running), 0);
        edges_m = 1;
        mon_clk = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            if (j == 2) mon_clk = 1'b0;
            if (j == 3) begin
                check("reen_first_edges", int'(edge_count), 1);
                check("reen_first_running", int'(running), 1);
            end
        end
        repeat (2) begin
            edges_m++;
            q_m.push_back('{4, 2, edges_m});
            mon_cycle(4, 2);
        end

        // Reset mid-measurement with a rise in the synchronizer
        mon_clk = 1'b1;
        repeat (2) @(negedge clk);
        check("pre_reset_period", int'(period), 4);
        reset_n = 1'b0;
        #1;
        check("midrst_running", int'(running), 0);
        check("midrst_stuck", int'(stuck), 0);
        check("midrst_period", int'(period), 0);
        check("midrst_high", int'(high_time), 0);
        check("midrst_pv", int'(period_valid), 0);
        check("midrst_edges", int'(edge_count), 0);
        mon_clk = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Narrow counter: slow clock hits timeout before every rise
        enable_s = 1'b1;
        repeat (2) @(negedge clk);
        repeat (3) begin
            edges_s++;
            cyc_s(20, 10);
            check("sat_slow_stuck", int'(stuck_s), 1);
            check("sat_slow_running", int'(running_s), 0);
        end
        // Period 14 stays under the timeout; first rise leaves STUCK without a period
        edges_s++;
        cyc_s(14, 7);
        repeat (14) begin
            edges_s++;
            q_s.push_back('{14, 7, (edges_s > 15) ? 15 : edges_s});
            cyc_s(14, 7);
        end
        // A 15-cycle interval: rise coincides with cnt at TIMEOUT-1, period is all-ones
        edges_s++;
        q_s.push_back('{14, 7, 15});
        cyc_s(15, 7);
        edges_s++;
        q_s.push_back('{15, 7, 15});
        cyc_s(20, 7);
        check("sat_edges_hold", int'(edge_count_s), 15);
        check("sat_period_ones", int'(period_s), 15);
        check("sat_final_stuck", int'(stuck_s), 1);

        repeat (10) @(negedge clk);
        check("pending_main", q_m.size(), 0);
        check("pending_small", q_s.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
